// File: rtl/smg_bcd_display.sv
// smg_bcd_display: sequential double-dabble binary-to-BCD converter driving registered 7-segment digits.
// Define SMG_LZ_BLANK_EN to blank leading zeros above the most significant nonzero digit.
module smg_bcd_display #(
    parameter int DIGITS      = 2,
    parameter int BIN_W       = 8,
    parameter bit SEG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  upd,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   hex_out
);
    function automatic int nd_f(input int w);
        longint m;
        int n;
        m = (longint'(1) << w) - 1;
        n = 0;
        while (m > 0) begin
            n++;
            m = m / 10;
        end
        return n;
    endfunction

    localparam int ND = nd_f(BIN_W);
    localparam int BW = 4 * ND;
    localparam int CW = $clog2(BIN_W + 1);

    function automatic logic [6:0] seg(input logic [3:0] d, input logic blank);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            default: s = 7'h6F;
        endcase
        s = blank ? 7'h00 : s;
        return SEG_ACT_LOW ? ~s : s;
    endfunction

    // Pad with zero digits so DIGITS > ND needs no special casing; {ovf, hex}.
    function automatic logic [7*DIGITS:0] disp(input logic [BW-1:0] b);
        logic [4*(ND+DIGITS)-1:0] p;
        logic [3:0]               dg;
        logic                     o;
        logic [7*DIGITS-1:0]      h;
`ifdef SMG_LZ_BLANK_EN
        logic                     nz;
        nz = 1'b0;
`endif
        p = {{(4*DIGITS){1'b0}}, b};
        o = |(p >> (4*DIGITS));
        h = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            dg = p[4*k +: 4];
`ifdef SMG_LZ_BLANK_EN
            nz = nz || dg != 4'd0 || k == 0;
            h[7*k +: 7] = seg(o ? 4'd9 : dg, !o && !nz);
`else
            h[7*k +: 7] = seg(o ? 4'd9 : dg, 1'b0);
`endif
        end
        return {o, h};
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cnt;
    logic [BIN_W-1:0]    r_sh, r_pend;
    logic                r_pend_v, r_upd, r_ovf;
    logic [BW-1:0]       r_bcd, w_add;
    logic [7*DIGITS-1:0] r_hex;
    logic                w_start;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_start = r_state == IDLE && (r_pend_v || load);
        w_next  = r_state == IDLE  ? (w_start ? SHIFT : IDLE) :
                  r_state == SHIFT ? (r_cnt == CW'(BIN_W - 1) ? OUT : SHIFT) : IDLE;
    end

    always_comb busy = r_state != IDLE;

    always_comb begin
        w_add = r_bcd;
        for (int k = 0; k < ND; k++)
            w_add[4*k +: 4] = r_bcd[4*k +: 4] >= 4'd5 ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_sh           <= '0;
            r_bcd          <= '0;
            r_pend         <= '0;
            r_pend_v       <= 1'b0;
            r_upd          <= 1'b0;
            {r_ovf, r_hex} <= disp('0);
        end else begin
            r_upd <= r_state == OUT;
            if (r_state == OUT) {r_ovf, r_hex} <= disp(r_bcd);
            if (w_start) begin
                r_sh  <= r_pend_v ? r_pend : value;
                r_bcd <= '0;
                r_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_sh  <= r_sh << 1;
                r_bcd <= BW'({w_add, r_sh[BIN_W-1]});
                r_cnt <= r_cnt + 1'b1;
            end
            // A load that cannot start now (busy, or pending queued ahead) replaces the pending slot.
            if (load && (r_state != IDLE || r_pend_v)) begin
                r_pend   <= value;
                r_pend_v <= 1'b1;
            end else if (w_start) begin
                r_pend_v <= 1'b0;
            end
        end
    end

    assign upd     = r_upd;
    assign ovf     = r_ovf;
    assign hex_out = r_hex;
endmodule

// File: tb/tb_smg_bcd_display.sv
// tb_smg_bcd_display: scoreboard bench for smg_bcd_display (DIGITS=2, BIN_W=8, SEG_ACT_LOW=1).
module tb_smg_bcd_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  value = '0;
    logic        load = 1'b0;
    logic        busy, upd, ovf;
    logic [13:0] hex_out;

    smg_bcd_display #(.DIGITS(2), .BIN_W(8), .SEG_ACT_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy), .upd(upd), .ovf(ovf), .hex_out(hex_out)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S5 = 7'h12;
    localparam logic [6:0] S6 = 7'h02, S7 = 7'h78, S9 = 7'h10;
`ifdef SMG_LZ_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    typedef struct {
        logic [13:0] hex;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0, fails = 0, cyc = 0, last_edge = 0, n_upd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && upd) begin
            n_upd++;
            if (sb.size() == 0) begin
                chk("unexpected_upd", {18'd0, hex_out}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("hex_out", {18'd0, hex_out}, {18'd0, e.hex});
                chk("ovf", {31'd0, ovf}, {31'd0, e.o});
                if (e.cyc != 0) chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic ld(input int v);
        @(negedge clk);
        value = 8'(v);
        load  = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        last_edge = cyc;
    endtask

    task automatic expect_v(input logic [6:0] h1, input logic [6:0] h0, input logic o, input bit timed);
        sb.push_back('{{h1, h0}, o, timed ? last_edge + 9 : 0});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_hex"}, {18'd0, hex_out}, {18'd0, LZ, S0});
        chk({nm, "_busy"}, {31'd0, busy}, 0);
        chk({nm, "_ovf"}, {31'd0, ovf}, 0);
        chk({nm, "_upd"}, {31'd0, upd}, 0);
    endtask

    initial begin
        int nb, u0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");

        ld(37);
        expect_v(S3, S7, 1'b0, 1'b1);
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            @(negedge clk);
        end
        chk("busy_cycles_37", nb, 9);
        drain();

        ld(99);  expect_v(S9, S9, 1'b0, 1'b1); drain();
        ld(255); expect_v(S9, S9, 1'b1, 1'b1); drain();
        ld(100); expect_v(S9, S9, 1'b1, 1'b1); drain();
        ld(0);   expect_v(LZ, S0, 1'b0, 1'b1); drain();
        ld(10);  expect_v(S1, S0, 1'b0, 1'b1); drain();
        ld(5);   expect_v(LZ, S5, 1'b0, 1'b1); drain();

        ld(12);
        expect_v(S1, S2, 1'b0, 1'b1);
        @(negedge clk);
        chk("busy_during_conv", {31'd0, busy}, 1);
        ld(34);
        ld(56);
        expect_v(S5, S6, 1'b0, 1'b0);
        drain();

        u0 = n_upd;
        ld(80);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("abort");
        nb = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("abort_no_pending", nb, 0);
        chk("abort_no_upd", n_upd - u0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
